// File: rtl/ig_pkg.sv
// Shared state encoding, default geometry and the {Gx,Gy} word layout for
// the image-gradient stream sequencer and anything consuming its output.
package ig_pkg;

   localparam int IG_IMG_W  = 256;
   localparam int IG_IMG_H  = 256;
   localparam int IG_PIX_W  = 8;
   localparam int IG_GRAD_W = 10;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2,
      FIN   = 2'd3
   } ig_state_t;

   function automatic logic [2*IG_GRAD_W-1:0] pack_grad(
      input logic [IG_GRAD_W-1:0] gx,
      input logic [IG_GRAD_W-1:0] gy
   );
      return {gx, gy};
   endfunction

endpackage

// File: rtl/ig_line_buf.sv
// One-row-plus-one-pixel pixel history. tap0 is the pixel being captured this
// cycle; taps 1..DEPTH are the registered history, so tapW is p(x,y).
module ig_line_buf
   import ig_pkg::*;
#(
   parameter int DEPTH = IG_IMG_W,
   parameter int PIX_W = IG_PIX_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_shift,
   input  logic [PIX_W-1:0] i_din,
   output logic [PIX_W-1:0] o_tap0,
   output logic [PIX_W-1:0] o_tap_wm1,
   output logic [PIX_W-1:0] o_tap_w
);

   logic [PIX_W-1:0] r_sr [DEPTH];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) r_sr[i] <= '0;
      end else if (i_shift) begin
         r_sr[0] <= i_din;
         for (int i = 1; i < DEPTH; i++) r_sr[i] <= r_sr[i-1];
      end
   end

   assign o_tap0    = i_din;
   assign o_tap_wm1 = r_sr[DEPTH-2];
   assign o_tap_w   = r_sr[DEPTH-1];

endmodule

// File: rtl/ig_stream_ctrl.sv
// Frame sequencer: streams the image once in raster order and writes the
// forward gradient {Gx,Gy} for every pixel, also in raster order.
//
//   state | meaning
//   IDLE  | waiting for start
//   READ  | issuing image reads, address 0..N-1
//   DRAIN | last captures plus IMG_W flush outputs in flight
//   FIN   | one-cycle done pulse
module ig_stream_ctrl
   import ig_pkg::*;
#(
   parameter int IMG_W  = IG_IMG_W,
   parameter int IMG_H  = IG_IMG_H,
   parameter int PIX_W  = IG_PIX_W,
   parameter int GRAD_W = IG_GRAD_W,
   parameter int ADDR_W = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   output logic                busy,
   output logic                done,
   output logic                img_rd,
   output logic [ADDR_W-1:0]   img_addr,
   input  logic [PIX_W-1:0]    img_di,
   output logic                grad_wr,
   output logic [ADDR_W-1:0]   grad_addr,
   output logic [2*GRAD_W-1:0] grad_do
);

   localparam int N  = IMG_W * IMG_H;
   localparam int XB = $clog2(IMG_W);
   localparam logic [ADDR_W-1:0] A_LAST = ADDR_W'(N - 1);
   localparam logic [ADDR_W-1:0] A_W    = ADDR_W'(IMG_W);
   localparam logic [ADDR_W-1:0] A_LROW = ADDR_W'(N - IMG_W);

   ig_state_t         r_state;
   logic              r_rd_d;
   logic              r_flush;
   logic [ADDR_W-1:0] r_cap;
   logic [ADDR_W-1:0] r_oc;

   logic              w_shift;
   logic              w_ov;
   logic              w_x_last;
   logic              w_y_last;
   logic [PIX_W-1:0]  w_tap0;
   logic [PIX_W-1:0]  w_tap_wm1;
   logic [PIX_W-1:0]  w_tap_w;
   logic [GRAD_W-1:0] w_gx;
   logic [GRAD_W-1:0] w_gy;

   ig_line_buf #(
      .DEPTH (IMG_W),
      .PIX_W (PIX_W)
   ) u_line_buf (
      .clk       (clk),
      .reset     (reset),
      .i_shift   (w_shift),
      .i_din     (img_di),
      .o_tap0    (w_tap0),
      .o_tap_wm1 (w_tap_wm1),
      .o_tap_w   (w_tap_w)
   );

   // r_rd_d marks the cycle img_di carries valid data; after the last capture
   // the buffer keeps shifting for IMG_W flush cycles to emit the last row.
   assign w_shift  = r_rd_d | r_flush;
   assign w_ov     = (r_rd_d && (r_cap >= A_W)) || r_flush;
   assign w_x_last = &r_oc[XB-1:0];
   assign w_y_last = (r_oc >= A_LROW);

   assign w_gx = w_x_last ? '0 : (GRAD_W'(w_tap_wm1) - GRAD_W'(w_tap_w));
   assign w_gy = w_y_last ? '0 : (GRAD_W'(w_tap0) - GRAD_W'(w_tap_w));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         img_rd    <= 1'b0;
         img_addr  <= '0;
         grad_wr   <= 1'b0;
         grad_addr <= '0;
         grad_do   <= '0;
         r_rd_d    <= 1'b0;
         r_flush   <= 1'b0;
         r_cap     <= '0;
         r_oc      <= '0;
      end else begin
         done    <= 1'b0;
         r_rd_d  <= img_rd;
         grad_wr <= w_ov;

         if (w_ov) begin
            grad_addr <= r_oc;
            grad_do   <= (2*GRAD_W)'(pack_grad(IG_GRAD_W'(w_gx), IG_GRAD_W'(w_gy)));
            r_oc      <= r_oc + 1'b1;
         end

         if (r_rd_d) r_cap <= r_cap + 1'b1;

         if (r_rd_d && (r_cap == A_LAST)) r_flush <= 1'b1;
         else if (r_flush && (r_oc == A_LAST)) r_flush <= 1'b0;

         case (r_state)
            IDLE: begin
               if (start) begin
                  r_state  <= READ;
                  busy     <= 1'b1;
                  img_rd   <= 1'b1;
                  img_addr <= '0;
                  r_cap    <= '0;
                  r_oc     <= '0;
               end
            end
            READ: begin
               if (img_addr == A_LAST) begin
                  img_rd  <= 1'b0;
                  r_state <= DRAIN;
               end else begin
                  img_addr <= img_addr + 1'b1;
               end
            end
            DRAIN: begin
               if (grad_wr && (grad_addr == A_LAST)) begin
                  r_state <= FIN;
                  busy    <= 1'b0;
                  done    <= 1'b1;
               end
            end
            FIN: r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ig_stream_ctrl.sv
// Self-checking bench for ig_stream_ctrl on a reduced 16x80 frame: scoreboard
// of every gradient write, a table of hand-derived words, and corner sequences.
module tb_ig_stream_ctrl;

   localparam int W  = 16;
   localparam int H  = 80;
   localparam int N  = W * H;
   localparam int AW = 16;
   localparam int PW = 8;
   localparam int GW = 10;

   localparam int P_CONST  = 0;
   localparam int P_HRAMP  = 1;
   localparam int P_VRAMP  = 2;
   localparam int P_BRIGHT = 3;
   localparam int P_RAND   = 4;

   typedef struct {
      int              pat;
      int              addr;
      logic [2*GW-1:0] exp;
   } vec_t;

   typedef struct {
      logic [AW-1:0]   addr;
      logic [2*GW-1:0] data;
   } sb_t;

   logic            clk   = 1'b0;
   logic            reset = 1'b1;
   logic            start = 1'b0;
   logic            busy, done, img_rd, grad_wr;
   logic [AW-1:0]   img_addr, grad_addr;
   logic [PW-1:0]   img_di = '0;
   logic [2*GW-1:0] grad_do;

   logic [PW-1:0]   img  [N];
   logic [2*GW-1:0] gcap [N];
   sb_t             sb_q [$];
   vec_t            vecs [$];

   int   n_chk = 0;
   int   n_fail = 0;
   int   cyc = 0;
   int   n_rd = 0, n_wr = 0, n_done = 0;
   int   t_rd0 = 0, t_wr0 = 0, t_done = 0;
   bit   rd_seen = 0, wr_seen = 0;
   logic          mem_rd = 1'b0;
   logic [AW-1:0] mem_a = '0;

   ig_stream_ctrl #(
      .IMG_W (W), .IMG_H (H), .PIX_W (PW), .GRAD_W (GW), .ADDR_W (AW)
   ) u_dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .busy      (busy),
      .done      (done),
      .img_rd    (img_rd),
      .img_addr  (img_addr),
      .img_di    (img_di),
      .grad_wr   (grad_wr),
      .grad_addr (grad_addr),
      .grad_do   (grad_do)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // image memory: one-cycle read latency, junk on the bus when not reading
   always @(negedge clk) begin
      mem_rd = img_rd;
      mem_a  = img_addr;
   end

   always @(posedge clk) begin
      #1;
      img_di = mem_rd ? img[mem_a] : PW'($urandom);
   end

   always @(negedge clk) begin
      sb_t e;
      cyc++;
      if (img_rd) begin
         n_rd++;
         if (!rd_seen) begin rd_seen = 1; t_rd0 = cyc; end
      end
      if (grad_wr) begin
         n_wr++;
         if (!wr_seen) begin wr_seen = 1; t_wr0 = cyc; end
         if (grad_addr < AW'(N)) gcap[grad_addr] = grad_do;
         if (sb_q.size() == 0) begin
            check("grad_wr_expected", 64'(sb_q.size() > 0), 1);
         end else begin
            e = sb_q.pop_front();
            check("grad_addr", grad_addr, e.addr);
            check("grad_do", grad_do, e.data);
         end
      end
      if (done) begin n_done++; t_done = cyc; end
   end

   function automatic logic [2*GW-1:0] ref_grad(input int a);
      int x, y, gx, gy;
      logic [GW-1:0] bx, by;
      x  = a % W;
      y  = a / W;
      gx = 0;
      gy = 0;
      if (x != W-1) gx = int'(img[a+1]) - int'(img[a]);
      if (y != H-1) gy = int'(img[a+W]) - int'(img[a]);
      bx = GW'(gx);
      by = GW'(gy);
      return {bx, by};
   endfunction

   task automatic load_img(input int pat);
      for (int a = 0; a < N; a++) begin
         case (pat)
            P_CONST:  img[a] = 8'h5A;
            P_HRAMP:  img[a] = PW'(a % W);
            P_VRAMP:  img[a] = PW'(a / W);
            P_BRIGHT: img[a] = (a == 0) ? 8'hFF : 8'h00;
            default:  img[a] = PW'($urandom_range(0, 255));
         endcase
      end
   endtask

   task automatic push_frame();
      sb_t e;
      for (int a = 0; a < N; a++) begin
         e.addr = AW'(a);
         e.data = ref_grad(a);
         sb_q.push_back(e);
         gcap[a] = '1;
      end
   endtask

   task automatic clear_counts();
      rd_seen = 0; wr_seen = 0;
      n_rd = 0; n_wr = 0; n_done = 0;
   endtask

   task automatic wait_done(output bit got);
      got = 0;
      for (int i = 0; i < N + W + 40 && !got; i++) begin
         @(negedge clk);
         if (done) got = 1;
      end
   endtask

   task automatic check_table(input int pat);
      foreach (vecs[i])
         if (vecs[i].pat == pat)
            check($sformatf("vec p%0d a%0d", pat, vecs[i].addr), gcap[vecs[i].addr], vecs[i].exp);
   endtask

   task automatic run_frame(input string nm, input bit poke);
      bit got;
      push_frame();
      clear_counts();
      @(posedge clk); #1 start = 1;
      @(posedge clk); #1 start = 0;
      if (poke) begin
         repeat (5) @(negedge clk);
         start = 1;
         @(negedge clk);
         start = 0;
         repeat (300) @(negedge clk);
         start = 1;
         @(negedge clk);
         start = 0;
      end
      wait_done(got);
      check($sformatf("%s done_seen", nm), 64'(got), 1);
      if (poke && got) begin
         start = 1;
         @(posedge clk); #1 start = 0;
      end
      repeat (4) @(negedge clk);
      check($sformatf("%s rd_count", nm), n_rd, N);
      check($sformatf("%s wr_count", nm), n_wr, N);
      check($sformatf("%s done_count", nm), n_done, 1);
      check($sformatf("%s sb_left", nm), sb_q.size(), 0);
      check($sformatf("%s first_wr_lat", nm), t_wr0 - t_rd0, W + 2);
      check($sformatf("%s done_lat", nm), t_done - t_rd0, W + N + 2);
      check($sformatf("%s busy_idle", nm), busy, 0);
      sb_q.delete();
   endtask

   initial begin
      bit got, seen;
      int gap;

      vecs.push_back('{P_CONST,  0,         20'h00000});
      vecs.push_back('{P_CONST,  N/2 + 7,   20'h00000});
      vecs.push_back('{P_CONST,  N - 1,     20'h00000});
      vecs.push_back('{P_HRAMP,  0,         20'h00400});
      vecs.push_back('{P_HRAMP,  W + 3,     20'h00400});
      vecs.push_back('{P_HRAMP,  W - 1,     20'h00000});
      vecs.push_back('{P_HRAMP,  N - W,     20'h00400});
      vecs.push_back('{P_HRAMP,  N - 1,     20'h00000});
      vecs.push_back('{P_VRAMP,  0,         20'h00001});
      vecs.push_back('{P_VRAMP,  W - 1,     20'h00001});
      vecs.push_back('{P_VRAMP,  5*W + 7,   20'h00001});
      vecs.push_back('{P_VRAMP,  N - W,     20'h00000});
      vecs.push_back('{P_VRAMP,  N - 1,     20'h00000});
      vecs.push_back('{P_BRIGHT, 0,         20'hC0701});
      vecs.push_back('{P_BRIGHT, 1,         20'h00000});
      vecs.push_back('{P_BRIGHT, W,         20'h00000});
      vecs.push_back('{P_BRIGHT, N - 1,     20'h00000});

      #2 reset = 0;
      repeat (3) @(negedge clk);
      check("reset_outputs", {busy, done, img_rd, img_addr, grad_wr, grad_addr, grad_do}, 0);
      #1 reset = 1;

      for (int p = P_CONST; p <= P_BRIGHT; p++) begin
         load_img(p);
         run_frame($sformatf("pat%0d", p), 0);
         check_table(p);
      end

      load_img(P_RAND);
      run_frame("rand_poke", 1);

      // start held high: second frame follows FIN via one IDLE cycle
      load_img(P_RAND);
      push_frame();
      push_frame();
      clear_counts();
      @(posedge clk); #1 start = 1;
      wait_done(got);
      check("held first_done", 64'(got), 1);
      gap = 0;
      seen = 0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk);
         gap++;
         if (img_rd) seen = 1;
      end
      check("held restart_gap", gap, 2);
      start = 0;
      wait_done(got);
      check("held second_done", 64'(got), 1);
      repeat (4) @(negedge clk);
      check("held wr_count", n_wr, 2*N);
      check("held done_count", n_done, 2);
      check("held sb_left", sb_q.size(), 0);
      sb_q.delete();

      // abort mid-frame after 1000 reads
      load_img(P_RAND);
      push_frame();
      clear_counts();
      @(posedge clk); #1 start = 1;
      @(posedge clk); #1 start = 0;
      seen = 0;
      for (int i = 0; i < 5 && !seen; i++) begin
         @(negedge clk);
         if (img_rd) seen = 1;
      end
      check("abort first_rd", 64'(seen), 1);
      repeat (999) @(negedge clk);
      check("abort img_addr", img_addr, 999);
      #1 reset = 0;
      #1 check("abort outputs_zero", {busy, done, img_rd, img_addr, grad_wr, grad_addr, grad_do}, 0);
      sb_q.delete();
      n_rd = 0;
      n_wr = 0;
      repeat (5) @(negedge clk);
      #1 reset = 1;
      repeat (20) @(negedge clk);
      check("abort no_reads", n_rd, 0);
      check("abort no_writes", n_wr, 0);
      check("abort busy", busy, 0);

      load_img(P_RAND);
      run_frame("after_abort", 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", n_chk, n_fail);
      $fatal(1, "watchdog expired");
   end

endmodule
